// File: rtl/cache_pkg.sv
// cache_pkg: shared FSM encoding and tag-word layout for cache_controller.
// Field positions below describe the default geometry (32/2/5).
package cache_pkg;

  localparam int DEF_ADDR_W   = 32;
  localparam int DEF_OFFSET_W = 2;
  localparam int DEF_IDX_W    = 5;
  localparam int DEF_DATA_W   = 32;

  localparam int TAG_W =
    DEF_ADDR_W - DEF_IDX_W - DEF_OFFSET_W;
  localparam int TAG_MEM_W = TAG_W + 2;
  localparam int VALID_POS = TAG_MEM_W - 1;
  localparam int DIRTY_POS = TAG_MEM_W - 2;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_COMPARE,
    S_WRITEBACK,
    S_ALLOCATE
  } state_t;

endpackage

// File: rtl/cache_perf_counters.sv
// cache_perf_counters: saturating hit/miss/write-back event counters.
// Built only when CACHE_STATS_EN is defined.
module cache_perf_counters (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic        hit_inc,
  input  logic        miss_inc,
  input  logic        wb_inc,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt,
  output logic [31:0] wb_cnt
);

  // count events, holding at all-ones
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
      wb_cnt   <= '0;
    end else begin
      if (hit_inc && hit_cnt != '1)
        hit_cnt <= hit_cnt + 32'd1;
      if (miss_inc && miss_cnt != '1)
        miss_cnt <= miss_cnt + 32'd1;
      if (wb_inc && wb_cnt != '1)
        wb_cnt <= wb_cnt + 32'd1;
    end
  end

endmodule

// File: rtl/cache_controller.sv
// cache_controller: direct-mapped write-back write-allocate cache FSM.
// Optional CACHE_STATS_EN adds hit_cnt/miss_cnt/wb_cnt outputs.
module cache_controller #(
  parameter  int ADDR_W    = 32,
  parameter  int OFFSET_W  = 2,
  parameter  int IDX_W     = 5,
  parameter  int DATA_W    = 32,
  localparam int TAG_W     = ADDR_W - IDX_W - OFFSET_W,
  localparam int TAG_MEM_W = TAG_W + 2
) (
  input  logic                 iCLK,
  input  logic                 iRST_N,
  input  logic                 cpu_req,
  input  logic                 cpu_we,
  input  logic [ADDR_W-1:0]    cpu_addr,
  input  logic [DATA_W-1:0]    cpu_wdata,
  output logic [DATA_W-1:0]    cpu_rdata,
  output logic                 cpu_ready,
  output logic                 busy,
  output logic                 tag_we,
  output logic [IDX_W-1:0]     idx,
  output logic [TAG_MEM_W-1:0] tag_block_in,
  input  logic [TAG_MEM_W-1:0] tag_block_out,
  output logic                 data_we,
  output logic [DATA_W-1:0]    data_wdata,
  input  logic [DATA_W-1:0]    data_rdata,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [DATA_W-1:0]    mem_wdata,
  input  logic [DATA_W-1:0]    mem_rdata,
`ifdef CACHE_STATS_EN
  output logic [31:0]          hit_cnt,
  output logic [31:0]          miss_cnt,
  output logic [31:0]          wb_cnt,
`endif
  input  logic                 mem_ack
);

  import cache_pkg::*;

  localparam int V_POS = TAG_MEM_W - 1;
  localparam int D_POS = TAG_MEM_W - 2;
  localparam logic [IDX_W-1:0] LAST_IDX = '1;
  localparam logic [OFFSET_W-1:0] NO_OFS = '0;

  state_t state, state_nx;

  logic [IDX_W-1:0]  sweep;
  logic              req_we;
  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  req_idx;
  logic [DATA_W-1:0] req_wdata;
  logic              req_ld;
  logic              tag_we_c;

  logic [TAG_W-1:0]  line_tag;
  logic              line_v;
  logic              line_d;
  logic              hit;

  logic unused_ofs;
  assign unused_ofs = ^cpu_addr[OFFSET_W-1:0];

  assign line_tag = tag_block_out[TAG_W-1:0];
  assign line_v   = tag_block_out[V_POS];
  assign line_d   = tag_block_out[D_POS];
  assign hit      = line_v && (line_tag == req_tag);

  // reset forces the sweep strobe and busy low
  assign tag_we = tag_we_c && iRST_N;
  assign busy   = (state != S_IDLE) && iRST_N;

  // state register
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) state <= S_INIT;
    else         state <= state_nx;
  end

  // invalidation sweep index, wraps back to zero
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N)              sweep <= '0;
    else if (state == S_INIT) sweep <= sweep + 1'b1;
  end

  // capture the CPU request on acceptance
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      req_we    <= 1'b0;
      req_tag   <= '0;
      req_idx   <= '0;
      req_wdata <= '0;
    end else if (req_ld) begin
      req_we    <= cpu_we;
      req_tag   <= cpu_addr[ADDR_W-1 -: TAG_W];
      req_idx   <= cpu_addr[OFFSET_W +: IDX_W];
      req_wdata <= cpu_wdata;
    end
  end

  // next state and all memory/CPU strobes
  always_comb begin
    state_nx     = state;
    req_ld       = 1'b0;
    tag_we_c     = 1'b0;
    tag_block_in = '0;
    data_we      = 1'b0;
    data_wdata   = '0;
    cpu_rdata    = '0;
    cpu_ready    = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    idx          = req_idx;
    unique case (state)
      S_INIT: begin
        idx      = sweep;
        tag_we_c = 1'b1;
        if (sweep == LAST_IDX)
          state_nx = S_IDLE;
      end
      S_IDLE: begin
        if (cpu_req) begin
          req_ld   = 1'b1;
          state_nx = S_COMPARE;
        end
      end
      S_COMPARE: begin
        if (hit) begin
          cpu_ready = 1'b1;
          state_nx  = S_IDLE;
          if (req_we) begin
            tag_we_c     = 1'b1;
            tag_block_in = {1'b1, 1'b1, req_tag};
            data_we      = 1'b1;
            data_wdata   = req_wdata;
          end else begin
            cpu_rdata = data_rdata;
          end
        end else if (line_v && line_d) begin
          state_nx = S_WRITEBACK;
        end else begin
          state_nx = S_ALLOCATE;
        end
      end
      S_WRITEBACK: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {line_tag, req_idx, NO_OFS};
        mem_wdata = data_rdata;
        if (mem_ack)
          state_nx = S_ALLOCATE;
      end
      S_ALLOCATE: begin
        mem_req  = 1'b1;
        mem_addr = {req_tag, req_idx, NO_OFS};
        if (mem_ack) begin
          tag_we_c     = 1'b1;
          tag_block_in = {1'b1, 1'b0, req_tag};
          data_we      = 1'b1;
          data_wdata   = mem_rdata;
          state_nx     = S_COMPARE;
        end
      end
      default: state_nx = S_INIT;
    endcase
  end

`ifdef CACHE_STATS_EN
  logic first_cmp;

  // marks the first compare of each request
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N)                 first_cmp <= 1'b0;
    else if (req_ld)             first_cmp <= 1'b1;
    else if (state == S_COMPARE) first_cmp <= 1'b0;
  end

  cache_perf_counters u_perf (
    .iCLK     (iCLK),
    .iRST_N   (iRST_N),
    .hit_inc  (state == S_COMPARE && first_cmp && hit),
    .miss_inc (state == S_COMPARE && first_cmp && !hit),
    .wb_inc   (state == S_WRITEBACK && mem_ack),
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt),
    .wb_cnt   (wb_cnt)
  );
`endif

endmodule
